apple_bus_seq: RTL and testbench
================================

# apple_bus_seq

Apple II bus-cycle sequencer for the card CPLD. It lives directly upstream of the register/DRAM control logic. It locks to the delayed PHI1 clock phase and produces the 7M state counter S, the refresh request, and the data-bus and ROM-select gating. It also latches the card-select and R/W status of each bus cycle so that downstream RAS/CAS and register logic only ever sees signals sampled at legal times. A watchdog drops sync if PHI1 edges stop arriving.

## Interface
- REF_DIV, 13: refresh divider; RefReq is asserted on one bus cycle in every REF_DIV.
- WDOG_MAX, 15: number of C7M cycles after S1 without a new PHI1 rise before sync is declared lost.
- C7M  in  1  7.16 MHz clock; all logic is on its rising edge.
- nRES  in  1  reset; synchronous, active-low.
- PHI1  in  1  delayed/hold-fixed PHI1 from the delay chain.
- nDEVSEL, nIOSEL, nIOSTRB, nWE  in  1 each  Apple II bus strobes, active-low.
- A  in  4  address bits 3:0.
- S  out  3  state: 0 = unsynced; 1..7 = position in the bus cycle, saturating at 7.
- RefReq  out  1  high during the S1 of a refresh cycle.
- DBEN  out  1  data-bus drive enable.
- CSEN  out  1  ROM chip-select enable.
- DevCyc, IoCyc, StrbCyc, WrCyc  out  1 each  sampled select / write status for the current cycle.
- RegIdx  out  4  A[3:0] sampled with DevCyc.
- LongCyc  out  1  the previous cycle was longer than 7 C7M periods.
- SyncLost  out  1  sticky flag; set by the watchdog, cleared by the next S1.

## Operation
- PHI1r holds PHI1 registered. PHI0seen is set on any edge where PHI1 = 0.
- Start event: PHI1 & ~PHI1r & PHI0seen. It sets S to 1 on that edge.
- Otherwise S holds at 0 if it is 0, holds at 7 if it is 7, and increments in all other cases.
- Cycle counter Cnt:
  - cleared to 0 on the start event, otherwise increments, saturating at WDOG_MAX.
  - On the start event, LongCyc <= (Cnt >= 7).
- Watchdog: when Cnt reaches WDOG_MAX, S <= 0, PHI0seen <= 0 and SyncLost <= 1 on that same edge. Resync then needs a PHI0 phase followed by a PHI1 rise.
- Refresh:
  - Ref counts 0..REF_DIV-1 and advances on edges where S == 3, wrapping to 0.
  - RefReq = (S == 1) & (Ref == 0), combinational from registers.
- Sampling:
  - On the edge where S == 4: DevCyc <= ~nDEVSEL, IoCyc <= ~nIOSEL, WrCyc <= ~nWE, RegIdx <= A.
  - StrbCyc <= ~nIOSTRB on the S == 3 edge, and is ORed with ~nIOSTRB on the S == 4 edge.
  - All four flags clear on the start event and hold otherwise.
- Gating:
  - DBEN <= S in {4,5,6,7}.
  - CSEN <= (S == 4 & nWE) | S in {5,6,7}.
  - Both use S before the edge's update.
- Simultaneous events:
  - Start event coinciding with Cnt == WDOG_MAX: the start event wins (S = 1, SyncLost cleared).
  - Start event while S == 0 is valid (initial lock).
- Reset values: every output and all internal state are 0, including PHI0seen, Ref and Cnt. Reset during a cycle forces S = 0 and requires a full relock.

## Timing
- Outputs are registered, except RefReq (decoded from registers, no input paths).
- Latency, with edge k being the start event:
  - S = 1 after edge k, S = 4 after edge k+3.
  - DBEN first goes high after edge k+4.
  - Select flags are valid after edge k+4 and stay valid through S7 until edge k+n, the next start event.
- Normal cycle: 7 edges (S1..S7). A long cycle holds S7 for one extra edge and sets LongCyc.
- Sample-legality rule: nDEVSEL and nIOSEL are sampled only at S4; nIOSTRB only at S3/S4.

## Structure
- Package apple_bus_pkg holds:
  - S encoding constants (S_IDLE = 0, S_SAMPLE = 4, S_MAX = 7);
  - REF_DIV and WDOG_MAX defaults;
  - a struct bundling DevCyc, IoCyc, StrbCyc, WrCyc and RegIdx.
- One sub-module, apple_ref_div, contains the Ref counter and RefReq decode.

## Test plan
- Reset then 10 cycles of PHI1 (3.5 high / 3.5 low C7M) -> S stays 0 until the first PHI1 rise after a low phase, then runs 1..7 each cycle; DBEN is high for 4 clocks per cycle.
- nDEVSEL low at S4 with nWE = 0 and A = 4'h3 -> DevCyc = 1, WrCyc = 1, RegIdx = 3 until the next S1; CSEN is low on the edge after S4 and high after S5.
- nIOSTRB low only during S3 -> StrbCyc = 1. nIOSEL low only during S2 -> IoCyc = 0.
- 26 consecutive cycles -> RefReq is asserted on exactly cycles 1 and 14.
- One 8-clock cycle -> S7 is held for 2 clocks and LongCyc = 1 at the next S1; a following 7-clock cycle sets LongCyc = 0.
- PHI1 stuck high for 20 clocks -> S = 0 and SyncLost = 1 exactly 15 clocks after S1. Sync is regained after a low phase plus a rise, SyncLost clears, and nRES low mid-cycle zeroes all outputs on the next edge.

Source files
------------

// File: rtl/apple_bus_seq_pkg.sv
// Shared constants and types for the Apple II bus-cycle sequencer.
// S is the position inside the bus cycle; 0 means not locked to PHI1.
package apple_bus_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FIRST    = 3'd1;
    localparam logic [2:0] S_PRE_SMP  = 3'd3;
    localparam logic [2:0] S_SAMPLE   = 3'd4;
    localparam logic [2:0] S_MAX      = 3'd7;

    localparam int REF_DIV_DEF  = 13;
    localparam int WDOG_MAX_DEF = 15;
    localparam int LONG_THRESH  = 7;

    typedef struct packed {
        logic       dev;
        logic       io;
        logic       strb;
        logic       wr;
        logic [3:0] reg_idx;
    } bus_sel_t;

    // Data bus is driven from the sample point to the end of the cycle.
    function automatic logic in_drive_window(input logic [2:0] s);
        return s >= S_SAMPLE;
    endfunction

endpackage

// File: rtl/apple_bus_seq_if.sv
// Apple II bus strobes in, sequencer state and gated status out.
// The sequencer is the slave side; the bus/bench side is the master.
interface apple_bus_seq_if;

    logic       PHI1;
    logic       nDEVSEL;
    logic       nIOSEL;
    logic       nIOSTRB;
    logic       nWE;
    logic [3:0] A;

    logic [2:0] S;
    logic       RefReq;
    logic       DBEN;
    logic       CSEN;
    logic       DevCyc;
    logic       IoCyc;
    logic       StrbCyc;
    logic       WrCyc;
    logic [3:0] RegIdx;
    logic       LongCyc;
    logic       SyncLost;

    modport slave (
        input  PHI1, nDEVSEL, nIOSEL, nIOSTRB, nWE, A,
        output S, RefReq, DBEN, CSEN, DevCyc, IoCyc, StrbCyc, WrCyc,
               RegIdx, LongCyc, SyncLost
    );

    modport master (
        output PHI1, nDEVSEL, nIOSEL, nIOSTRB, nWE, A,
        input  S, RefReq, DBEN, CSEN, DevCyc, IoCyc, StrbCyc, WrCyc,
               RegIdx, LongCyc, SyncLost
    );

endinterface

// File: rtl/apple_bus_seq_ref_div.sv
// Refresh divider: one refresh request every REF_DIV bus cycles.
// Advances at S3 so the S1 decode sees a stable count.
module apple_ref_div
    import apple_bus_pkg::*;
#(
    parameter int REF_DIV = REF_DIV_DEF
) (
    input  logic       C7M,
    input  logic       nRES,
    input  logic [2:0] s,
    output logic       ref_req
);

    localparam int REF_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_DIV - 1);

    logic [REF_W-1:0] ref_q;
    logic [REF_W-1:0] ref_d;

    always_comb begin
        ref_d = ref_q;
        if (s == S_PRE_SMP) begin
            ref_d = (ref_q == REF_LAST) ? '0 : ref_q + REF_W'(1);
        end
        ref_req = (s == S_FIRST) && (ref_q == '0);
    end

    always_ff @(posedge C7M) begin
        if (!nRES) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_d;
        end
    end

endmodule

// File: rtl/apple_bus_seq.sv
// Bus-cycle sequencer: locks S to PHI1 rises, samples selects at legal
// points, gates DBEN/CSEN and drops sync if PHI1 stops.
//
// state (S) | meaning
// ----------+-----------------------------------------------
// 0         | unsynced, waiting for PHI0 then a PHI1 rise
// 1         | cycle start, refresh decode point
// 2         | address settling
// 3         | nIOSTRB first sample, refresh divider advances
// 4         | select / write / address sample point
// 5..6      | data phase, bus driven
// 7         | data phase, held here until next PHI1 rise
module apple_bus_seq
    import apple_bus_pkg::*;
#(
    parameter int REF_DIV  = REF_DIV_DEF,
    parameter int WDOG_MAX = WDOG_MAX_DEF
) (
    input  logic            C7M,
    input  logic            nRES,
    apple_bus_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WDOG_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WDOG_MAX);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(WDOG_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_THRESH);

    logic             phi1r_q,     phi1r_d;
    logic             phi0_seen_q, phi0_seen_d;
    logic [2:0]       s_q,         s_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             long_q,      long_d;
    logic             sync_lost_q, sync_lost_d;
    logic             dben_q,      dben_d;
    logic             csen_q,      csen_d;
    bus_sel_t         sel_q,       sel_d;

    logic start;
    logic wdog_trip;
    logic ref_req;

    always_comb begin
        start     = bus.PHI1 & ~phi1r_q & phi0_seen_q;
        // Trip only on the edge Cnt arrives at the limit, so a saturated
        // counter cannot keep clearing PHI0seen and block relock.
        wdog_trip = ~start & (cnt_q == CNT_TRIP);

        phi1r_d     = bus.PHI1;
        phi0_seen_d = phi0_seen_q | ~bus.PHI1;
        s_d         = s_q;
        cnt_d       = cnt_q;
        long_d      = long_q;
        sync_lost_d = sync_lost_q;

        if (start) begin
            s_d         = S_FIRST;
            cnt_d       = '0;
            long_d      = (cnt_q >= CNT_LONG);
            sync_lost_d = 1'b0;
        end else begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
            if (wdog_trip) begin
                s_d         = S_IDLE;
                phi0_seen_d = 1'b0;
                sync_lost_d = 1'b1;
            end else if (s_q != S_IDLE && s_q != S_MAX) begin
                s_d = s_q + 3'd1;
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (start) begin
            sel_d.dev  = 1'b0;
            sel_d.io   = 1'b0;
            sel_d.strb = 1'b0;
            sel_d.wr   = 1'b0;
        end else if (s_q == S_PRE_SMP) begin
            sel_d.strb = ~bus.nIOSTRB;
        end else if (s_q == S_SAMPLE) begin
            sel_d.dev     = ~bus.nDEVSEL;
            sel_d.io      = ~bus.nIOSEL;
            sel_d.wr      = ~bus.nWE;
            sel_d.strb    = sel_q.strb | ~bus.nIOSTRB;
            sel_d.reg_idx = bus.A;
        end

        // ROM select waits one state on writes so the ROM never fights the bus.
        dben_d = in_drive_window(s_q);
        csen_d = ((s_q == S_SAMPLE) & bus.nWE) | (s_q > S_SAMPLE);
    end

    always_ff @(posedge C7M) begin
        if (!nRES) begin
            phi1r_q     <= 1'b0;
            phi0_seen_q <= 1'b0;
            s_q         <= S_IDLE;
            cnt_q       <= '0;
            long_q      <= 1'b0;
            sync_lost_q <= 1'b0;
            dben_q      <= 1'b0;
            csen_q      <= 1'b0;
            sel_q       <= '0;
        end else begin
            phi1r_q     <= phi1r_d;
            phi0_seen_q <= phi0_seen_d;
            s_q         <= s_d;
            cnt_q       <= cnt_d;
            long_q      <= long_d;
            sync_lost_q <= sync_lost_d;
            dben_q      <= dben_d;
            csen_q      <= csen_d;
            sel_q       <= sel_d;
        end
    end

    apple_ref_div #(
        .REF_DIV (REF_DIV)
    ) u_ref_div (
        .C7M     (C7M),
        .nRES    (nRES),
        .s       (s_q),
        .ref_req (ref_req)
    );

    assign bus.S        = s_q;
    assign bus.RefReq   = ref_req;
    assign bus.DBEN     = dben_q;
    assign bus.CSEN     = csen_q;
    assign bus.DevCyc   = sel_q.dev;
    assign bus.IoCyc    = sel_q.io;
    assign bus.StrbCyc  = sel_q.strb;
    assign bus.WrCyc    = sel_q.wr;
    assign bus.RegIdx   = sel_q.reg_idx;
    assign bus.LongCyc  = long_q;
    assign bus.SyncLost = sync_lost_q;

endmodule

// File: tb/tb_apple_bus_seq.sv
// Scoreboard bench for apple_bus_seq: stimulus queues per-cycle expectations,
// a monitor closes each bus cycle at the next S1 and compares.
module tb_apple_bus_seq;

    logic C7M  = 1'b0;
    logic nRES = 1'b0;

    apple_bus_seq_if bus ();

    apple_bus_seq dut (
        .C7M  (C7M),
        .nRES (nRES),
        .bus  (bus)
    );

    always #5 C7M = ~C7M;

    typedef struct {
        int         len;
        int         s7;
        int         dben;
        int         refc;
        logic       csen5;
        logic       csen6;
        logic       dev;
        logic       io;
        logic       strb;
        logic       wr;
        logic [3:0] idx;
        logic       lng;
    } exp_t;

    exp_t sb_q[$];
    int   wd_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_S"},        bus.S,        0);
        chk({tag, "_RefReq"},   bus.RefReq,   0);
        chk({tag, "_DBEN"},     bus.DBEN,     0);
        chk({tag, "_CSEN"},     bus.CSEN,     0);
        chk({tag, "_DevCyc"},   bus.DevCyc,   0);
        chk({tag, "_IoCyc"},    bus.IoCyc,    0);
        chk({tag, "_StrbCyc"},  bus.StrbCyc,  0);
        chk({tag, "_WrCyc"},    bus.WrCyc,    0);
        chk({tag, "_RegIdx"},   bus.RegIdx,   0);
        chk({tag, "_LongCyc"},  bus.LongCyc,  0);
        chk({tag, "_SyncLost"}, bus.SyncLost, 0);
    endtask

    // One bus cycle of n_len clocks: PHI1 high for 4 edges, low for the rest.
    // Mask bit j means the strobe is low on the edge where S (before update) is j.
    task automatic bus_cycle(input int n_len, input logic [7:0] dev_m, input logic [7:0] io_m,
                             input logic [7:0] strb_m, input logic [7:0] we_m, input logic [3:0] addr,
                             input logic e_dev, input logic e_io, input logic e_strb, input logic e_wr,
                             input logic e_ref, input bit push);
        exp_t e;
        if (push) begin
            e.len   = n_len;
            e.s7    = n_len - 6;
            e.dben  = n_len - 3;
            e.refc  = e_ref ? 1 : 0;
            e.csen5 = ~we_m[4];
            e.csen6 = 1'b1;
            e.dev   = e_dev;
            e.io    = e_io;
            e.strb  = e_strb;
            e.wr    = e_wr;
            e.idx   = addr;
            e.lng   = (n_len > 7);
            sb_q.push_back(e);
        end
        for (int j = 0; j < n_len; j++) begin
            @(negedge C7M);
            bus.PHI1    = (j < 4);
            bus.nDEVSEL = ~dev_m[j];
            bus.nIOSEL  = ~io_m[j];
            bus.nIOSTRB = ~strb_m[j];
            bus.nWE     = ~we_m[j];
            bus.A       = addr;
        end
    endtask

    task automatic idle_clocks(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge C7M);
            bus.PHI1    = 1'b0;
            bus.nDEVSEL = 1'b1;
            bus.nIOSEL  = 1'b1;
            bus.nIOSTRB = 1'b1;
            bus.nWE     = 1'b1;
        end
    endtask

    // Monitor state
    int         m_idx    = 0;
    int         m_s1_idx = 0;
    int         m_len    = 0;
    int         m_s7     = 0;
    int         m_dben   = 0;
    int         m_refc   = 0;
    int         m_cyc    = 0;
    bit         m_win    = 0;
    bit         m_wdpend = 0;
    logic       m_sl_prev = 1'b0;
    logic       m_c5, m_c6, m_dev, m_io, m_strb, m_wr;
    logic [3:0] m_idxv;

    initial begin
        exp_t e;
        int   gap;
        forever begin
            @(negedge C7M);
            m_idx++;
            if (bus.SyncLost === 1'b1 && m_sl_prev !== 1'b1) begin
                if (wd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wd_unexpected: SyncLost rose with no watchdog event queued");
                end else begin
                    gap = wd_q.pop_front();
                    chk("wd_gap", m_idx - m_s1_idx, gap);
                    chk("wd_S", bus.S, 0);
                    m_wdpend = 1;
                end
            end
            m_sl_prev = bus.SyncLost;

            if (bus.S == 3'd1) begin
                if (m_win) begin
                    m_cyc++;
                    m_dben += int'(bus.DBEN);
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL cycle_unexpected: cycle %0d completed with nothing queued", m_cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("c%0d_len", m_cyc),     m_len,  e.len);
                        chk($sformatf("c%0d_s7hold", m_cyc),  m_s7,   e.s7);
                        chk($sformatf("c%0d_dben", m_cyc),    m_dben, e.dben);
                        chk($sformatf("c%0d_refreq", m_cyc),  m_refc, e.refc);
                        chk($sformatf("c%0d_csen_s5", m_cyc), m_c5,   e.csen5);
                        chk($sformatf("c%0d_csen_s6", m_cyc), m_c6,   e.csen6);
                        chk($sformatf("c%0d_dev", m_cyc),     m_dev,  e.dev);
                        chk($sformatf("c%0d_io", m_cyc),      m_io,   e.io);
                        chk($sformatf("c%0d_strb", m_cyc),    m_strb, e.strb);
                        chk($sformatf("c%0d_wr", m_cyc),      m_wr,   e.wr);
                        chk($sformatf("c%0d_regidx", m_cyc),  m_idxv, e.idx);
                        chk($sformatf("c%0d_longcyc", m_cyc), bus.LongCyc, e.lng);
                        chk($sformatf("c%0d_synclost", m_cyc), bus.SyncLost, 0);
                        chk($sformatf("c%0d_flags_clr", m_cyc),
                            {bus.DevCyc, bus.IoCyc, bus.StrbCyc, bus.WrCyc}, 0);
                    end
                end
                if (m_wdpend) begin
                    chk("synclost_clear", bus.SyncLost, 0);
                    m_wdpend = 0;
                end
                m_win    = 1;
                m_s1_idx = m_idx;
                m_len    = 1;
                m_s7     = 0;
                m_dben   = 0;
                m_refc   = int'(bus.RefReq);
                m_c5     = 1'bx;
                m_c6     = 1'bx;
            end else if (bus.S == 3'd0) begin
                m_win = 0;
            end else if (m_win) begin
                m_len++;
                m_dben += int'(bus.DBEN);
                m_refc += int'(bus.RefReq);
                if (bus.S == 3'd5) m_c5 = bus.CSEN;
                if (bus.S == 3'd6) m_c6 = bus.CSEN;
                if (bus.S == 3'd7) begin
                    m_s7++;
                    m_dev  = bus.DevCyc;
                    m_io   = bus.IoCyc;
                    m_strb = bus.StrbCyc;
                    m_wr   = bus.WrCyc;
                    m_idxv = bus.RegIdx;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bus.PHI1    = 1'b0;
        bus.nDEVSEL = 1'b1;
        bus.nIOSEL  = 1'b1;
        bus.nIOSTRB = 1'b1;
        bus.nWE     = 1'b1;
        bus.A       = 4'h0;

        repeat (3) @(negedge C7M);
        chk_zero("rst");

        // PHI1 already high at release: no PHI0 seen yet, so no lock.
        nRES     = 1'b1;
        bus.PHI1 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge C7M);
            chk("prelock_hi_S", bus.S, 0);
        end
        bus.PHI1 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge C7M);
            chk("prelock_lo_S", bus.S, 0);
        end

        for (int n = 1; n <= 28; n++) begin
            int         len;
            logic [7:0] dm, im, sm, wm;
            logic [3:0] ad;
            logic       ed, ei, es, ew;
            len = 7;
            dm = 8'h00; im = 8'h00; sm = 8'h00; wm = 8'h00;
            ad = 4'(n);
            ed = 1'b0; ei = 1'b0; es = 1'b0; ew = 1'b0;
            case (n)
                3:  begin dm = 8'h10; wm = 8'h10; ad = 4'h3; ed = 1'b1; ew = 1'b1; end
                4:  begin sm = 8'h08; ad = 4'h5; es = 1'b1; end
                5:  begin im = 8'h04; ad = 4'h9; end
                6:  begin im = 8'h10; sm = 8'h10; ad = 4'hC; ei = 1'b1; es = 1'b1; end
                7:  begin dm = 8'h28; sm = 8'h20; wm = 8'h08; ad = 4'hF; end
                8:  begin dm = 8'h70; sm = 8'h18; wm = 8'h10; ad = 4'h0; ed = 1'b1; es = 1'b1; ew = 1'b1; end
                27: len = 8;
                default: ;
            endcase
            bus_cycle(len, dm, im, sm, wm, ad, ed, ei, es, ew, (n == 1 || n == 14 || n == 27), 1);
        end

        // PHI1 stuck high: watchdog fires 15 clocks after S1, then relock.
        wd_q.push_back(15);
        for (int j = 0; j < 23; j++) begin
            @(negedge C7M);
            bus.PHI1 = (j < 20);
        end
        bus_cycle(7, 8'h00, 8'h00, 8'h00, 8'h00, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Partial cycle interrupted by reset after the S4 sample.
        for (int j = 0; j < 5; j++) begin
            @(negedge C7M);
            bus.PHI1    = (j < 4);
            bus.nDEVSEL = (j != 4);
            bus.A       = 4'hA;
        end
        @(negedge C7M);
        chk("premid_S", bus.S, 5);
        chk("premid_DBEN", bus.DBEN, 1);
        chk("premid_DevCyc", bus.DevCyc, 1);
        chk("premid_RegIdx", bus.RegIdx, 4'hA);
        nRES        = 1'b0;
        bus.PHI1    = 1'b0;
        bus.nDEVSEL = 1'b1;
        @(negedge C7M);
        chk_zero("midrst");
        nRES = 1'b1;
        idle_clocks(3);

        // Relock after reset: refresh divider restarted, so first cycle refreshes.
        bus_cycle(7, 8'h00, 8'h10, 8'h00, 8'h00, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        bus_cycle(7, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle_clocks(3);

        chk("sb_left", sb_q.size(), 0);
        chk("wd_left", wd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
